// File: rtl/psw_pkg.sv
// Shared definitions for the processor status word unit.
//   Flag bit positions, ALU op codes with the helper that returns the
//   per-op flag update mask, and branch condition selector codes.
package psw_pkg;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_RSV2 = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_XOR  = 3'b101;
   localparam logic [2:0] ALU_SHF  = 3'b110;
   localparam logic [2:0] ALU_RSV7 = 3'b111;

   localparam logic [2:0] COND_ALWAYS = 3'b000;
   localparam logic [2:0] COND_Z      = 3'b001;
   localparam logic [2:0] COND_NZ     = 3'b010;
   localparam logic [2:0] COND_N      = 3'b011;
   localparam logic [2:0] COND_NN     = 3'b100;
   localparam logic [2:0] COND_C      = 3'b101;
   localparam logic [2:0] COND_V      = 3'b110;
   localparam logic [2:0] COND_NEVER  = 3'b111;

   // Bit i set means flag i takes the ALU's candidate value.
   // Arithmetic ops own all four flags; logic/shift ops leave C and V alone.
   function automatic logic [3:0] alu_flag_mask(input logic [2:0] op);
      logic [3:0] m;
      case (op)
         ALU_ADD, ALU_SUB:                m = 4'b1111;
         ALU_AND, ALU_OR, ALU_XOR, ALU_SHF: m = 4'b0011;
         default:                         m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/psw_shadow_stack.sv
// Bounded LIFO holding saved {IE,flags} words across nested interrupts.
//   clk, reset       : clock, synchronous active-high reset (clears count/err)
//   push, pop, din   : push has priority when both are asserted
//   err_clr          : clears sticky err; a new error in the same cycle wins
//   dout             : top-of-stack entry (zero when empty)
//   full, empty, err : status decoded from registered state only
module psw_shadow_stack #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign wr_idx = count[IDX_W-1:0];
   assign rd_idx = IDX_W'(count - CNT_W'(1));
   assign dout   = empty ? '0 : mem[rd_idx];

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (push && !full)
         count <= count + CNT_W'(1);
      else if (!push && pop && !empty)
         count <= count - CNT_W'(1);
   end

   // Entries are not reset: a cleared count already makes them unreachable.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_idx] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else if ((push && full) || (!push && pop && empty))
         err <= 1'b1;
      else if (err_clr)
         err <= 1'b0;
   end

endmodule

// File: rtl/psw_ctrl.sv
// Processor status word unit: Z/N/C/V flags plus interrupt enable, with
// masked ALU updates, bus load, condition evaluation and an interrupt
// shadow stack.
//   clk, reset            : clock, synchronous active-high reset
//   bus_in, psw_latch     : load {IE,flags} from bus_in[FLAG_W:0]
//   alu_upd, alu_op, cc_* : masked flag update from the ALU
//   ie_set, ie_clr        : interrupt enable control (clear wins)
//   irq_entry, irq_return : push/pop PSW on the shadow stack
//   err_clr               : clear sticky stack_err
//   cond_sel, cond_true   : combinational branch condition on current flags
//   psw_out               : {zeros, IE, flags}
//   stack_full/empty/err  : shadow stack status
import psw_pkg::*;

module psw_ctrl #(
   parameter int DATA_W      = 16,
   parameter int FLAG_W      = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              psw_latch,
   input  logic              alu_upd,
   input  logic [2:0]        alu_op,
   input  logic              cc_z,
   input  logic              cc_n,
   input  logic              cc_c,
   input  logic              cc_v,
   input  logic              ie_set,
   input  logic              ie_clr,
   input  logic              irq_entry,
   input  logic              irq_return,
   input  logic              err_clr,
   input  logic [2:0]        cond_sel,
   output logic              cond_true,
   output logic [DATA_W-1:0] psw_out,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_err
);

   logic [FLAG_W-1:0] flags, flags_nxt;
   logic              ie, ie_nxt;
   logic              do_return, do_latch, do_ie, do_alu;
   logic [FLAG_W:0]   stk_dout;
   logic [3:0]        cc;
   logic [3:0]        upd_mask;
   logic [3:0]        f4;

   // Only the highest-priority action of the cycle is allowed through.
   always_comb begin
      do_return = irq_return && !irq_entry;
      do_latch  = psw_latch && !irq_entry && !irq_return;
      do_ie     = (ie_set || ie_clr) && !irq_entry && !irq_return && !psw_latch;
      do_alu    = alu_upd && !irq_entry && !irq_return && !psw_latch
                  && !ie_set && !ie_clr;
   end

   assign cc       = {cc_v, cc_c, cc_n, cc_z};
   assign upd_mask = alu_flag_mask(alu_op);

   always_comb begin
      flags_nxt = flags;
      ie_nxt    = ie;
      if (irq_entry) begin
         ie_nxt = 1'b0;
      end else if (do_return) begin
         if (!stack_empty)
            {ie_nxt, flags_nxt} = stk_dout;
      end else if (do_latch) begin
         {ie_nxt, flags_nxt} = bus_in[FLAG_W:0];
      end else if (do_ie) begin
         ie_nxt = !ie_clr;
      end else if (do_alu) begin
         for (int i = 0; i < FLAG_W; i++)
            if (upd_mask[i])
               flags_nxt[i] = cc[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= '0;
         ie    <= 1'b0;
      end else begin
         flags <= flags_nxt;
         ie    <= ie_nxt;
      end
   end

   psw_shadow_stack #(
      .WIDTH (FLAG_W + 1),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk     (clk),
      .reset   (reset),
      .push    (irq_entry),
      .pop     (do_return),
      .err_clr (err_clr),
      .din     ({ie, flags}),
      .dout    (stk_dout),
      .full    (stack_full),
      .empty   (stack_empty),
      .err     (stack_err)
   );

   always_comb begin
      psw_out             = '0;
      psw_out[FLAG_W:0]   = {ie, flags};
   end

   // Missing C/V (FLAG_W=2) read as zero so their conditions are never true.
   always_comb begin
      f4             = '0;
      f4[FLAG_W-1:0] = flags;
      case (cond_sel)
         COND_ALWAYS: cond_true = 1'b1;
         COND_Z:      cond_true = f4[FLAG_Z];
         COND_NZ:     cond_true = !f4[FLAG_Z];
         COND_N:      cond_true = f4[FLAG_N];
         COND_NN:     cond_true = !f4[FLAG_N];
         COND_C:      cond_true = f4[FLAG_C];
         COND_V:      cond_true = f4[FLAG_V];
         default:     cond_true = 1'b0;
      endcase
   end

   generate
      if (DATA_W > FLAG_W + 1) begin : g_unused_bus
         logic unused_bus_hi;
         assign unused_bus_hi = ^bus_in[DATA_W-1:FLAG_W+1];
      end
   endgenerate

endmodule

// File: tb/tb_psw_ctrl.sv
// Directed bench for psw_ctrl with a queue-based scoreboard: each driven
// cycle pushes its hand-computed expected outputs, and a monitor pops and
// compares them after the following clock edge.
module tb_psw_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] bus_in;
   logic        psw_latch, alu_upd;
   logic [2:0]  alu_op;
   logic        cc_z, cc_n, cc_c, cc_v;
   logic        ie_set, ie_clr, irq_entry, irq_return, err_clr;
   logic [2:0]  cond_sel;
   logic        cond_true;
   logic [15:0] psw_out;
   logic        stack_full, stack_empty, stack_err;

   typedef struct {
      string       name;
      logic [15:0] psw;
      logic        full;
      logic        empty;
      logic        err;
      logic        cond;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   psw_ctrl #(.DATA_W(16), .FLAG_W(4), .STACK_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_in      (bus_in),
      .psw_latch   (psw_latch),
      .alu_upd     (alu_upd),
      .alu_op      (alu_op),
      .cc_z        (cc_z),
      .cc_n        (cc_n),
      .cc_c        (cc_c),
      .cc_v        (cc_v),
      .ie_set      (ie_set),
      .ie_clr      (ie_clr),
      .irq_entry   (irq_entry),
      .irq_return  (irq_return),
      .err_clr     (err_clr),
      .cond_sel    (cond_sel),
      .cond_true   (cond_true),
      .psw_out     (psw_out),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   task automatic clear_inputs();
      reset = 1'b0; bus_in = '0; psw_latch = 1'b0; alu_upd = 1'b0;
      alu_op = '0; cc_z = 1'b0; cc_n = 1'b0; cc_c = 1'b0; cc_v = 1'b0;
      ie_set = 1'b0; ie_clr = 1'b0; irq_entry = 1'b0; irq_return = 1'b0;
      err_clr = 1'b0; cond_sel = '0;
   endtask

   task automatic begin_cyc();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic expect_v(input string name, input logic [15:0] psw,
                           input logic full, input logic empty,
                           input logic err, input logic cond);
      exp_t e;
      e.name = name; e.psw = psw; e.full = full; e.empty = empty;
      e.err = err; e.cond = cond;
      exp_q.push_back(e);
   endtask

   task automatic set_cc(input logic [3:0] vcnz);
      {cc_v, cc_c, cc_n, cc_z} = vcnz;
   endtask

   // Monitor: results of the inputs driven before an edge are sampled
   // shortly after that edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (psw_out !== e.psw || stack_full !== e.full ||
                stack_empty !== e.empty || stack_err !== e.err ||
                cond_true !== e.cond) begin
               n_miss++;
               $display("FAIL %s: got psw=%h full=%b empty=%b err=%b cond=%b, want psw=%h full=%b empty=%b err=%b cond=%b",
                        e.name, psw_out, stack_full, stack_empty, stack_err, cond_true,
                        e.psw, e.full, e.empty, e.err, e.cond);
            end
         end
      end
   end

   initial begin
      clear_inputs();
      reset = 1'b1;

      begin_cyc(); reset = 1;                                  expect_v("reset",        16'h0000, 0, 1, 0, 1);
      begin_cyc(); alu_upd = 1; alu_op = 3'b000; set_cc(4'b0101); cond_sel = 3'b001;
                                                                expect_v("add_flags",    16'h0005, 0, 1, 0, 1);
      begin_cyc(); cond_sel = 3'b101;                          expect_v("cond_c",       16'h0005, 0, 1, 0, 1);
      begin_cyc(); cond_sel = 3'b010;                          expect_v("cond_nz",      16'h0005, 0, 1, 0, 0);
      begin_cyc(); psw_latch = 1; bus_in = 16'h000F; cond_sel = 3'b110;
                                                                expect_v("latch_f",      16'h000F, 0, 1, 0, 1);
      begin_cyc(); alu_upd = 1; alu_op = 3'b011; set_cc(4'b0000); cond_sel = 3'b100;
                                                                expect_v("logic_hold_cv",16'h000C, 0, 1, 0, 1);
      begin_cyc(); alu_upd = 1; alu_op = 3'b111; set_cc(4'b1111); cond_sel = 3'b111;
                                                                expect_v("op7_noupd",    16'h000C, 0, 1, 0, 0);
      begin_cyc(); alu_upd = 1; alu_op = 3'b010; set_cc(4'b1111); expect_v("op2_noupd",  16'h000C, 0, 1, 0, 1);
      begin_cyc(); psw_latch = 1; bus_in = 16'h001A; alu_upd = 1; alu_op = 3'b000; set_cc(4'b0000);
                   cond_sel = 3'b011;                          expect_v("latch_wins",   16'h001A, 0, 1, 0, 1);
      begin_cyc(); ie_set = 1; ie_clr = 1;                     expect_v("ie_clr_wins",  16'h000A, 0, 1, 0, 1);
      begin_cyc(); ie_set = 1;                                 expect_v("ie_set",       16'h001A, 0, 1, 0, 1);
      begin_cyc(); alu_upd = 1; alu_op = 3'b001; set_cc(4'b1000); expect_v("sub_v",      16'h0018, 0, 1, 0, 1);
      begin_cyc(); ie_clr = 1; alu_upd = 1; alu_op = 3'b000; set_cc(4'b1111);
                                                                expect_v("ie_over_alu",  16'h0008, 0, 1, 0, 1);

      // Fill the shadow stack with distinct PSWs.
      begin_cyc(); psw_latch = 1; bus_in = 16'h0011;           expect_v("load1",        16'h0011, 0, 1, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push1",        16'h0001, 0, 0, 0, 1);
      begin_cyc(); psw_latch = 1; bus_in = 16'h0012;           expect_v("load2",        16'h0012, 0, 0, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push2",        16'h0002, 0, 0, 0, 1);
      begin_cyc(); psw_latch = 1; bus_in = 16'h0013;           expect_v("load3",        16'h0013, 0, 0, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push3",        16'h0003, 0, 0, 0, 1);
      begin_cyc(); psw_latch = 1; bus_in = 16'h0014;           expect_v("load4",        16'h0014, 0, 0, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push4_full",   16'h0004, 1, 0, 0, 1);
      begin_cyc(); psw_latch = 1; bus_in = 16'h001F;           expect_v("load5",        16'h001F, 1, 0, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push_ovf",     16'h000F, 1, 0, 1, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop4",         16'h0014, 0, 0, 1, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop3",         16'h0013, 0, 0, 1, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop2",         16'h0012, 0, 0, 1, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop1",         16'h0011, 0, 1, 1, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop_unf",      16'h0011, 0, 1, 1, 1);
      begin_cyc(); err_clr = 1;                                expect_v("err_clr",      16'h0011, 0, 1, 0, 1);
      begin_cyc(); irq_return = 1; err_clr = 1;                expect_v("err_set_wins", 16'h0011, 0, 1, 1, 1);
      begin_cyc(); err_clr = 1;                                expect_v("err_clr2",     16'h0011, 0, 1, 0, 1);

      // Simultaneous entry and return with one entry already saved.
      begin_cyc(); irq_entry = 1;                              expect_v("push_a",       16'h0001, 0, 0, 0, 1);
      begin_cyc(); ie_set = 1;                                 expect_v("ie_on",        16'h0011, 0, 0, 0, 1);
      begin_cyc(); irq_entry = 1; irq_return = 1;              expect_v("entry_and_ret",16'h0001, 0, 0, 0, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop_b",        16'h0011, 0, 0, 0, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop_a",        16'h0011, 0, 1, 0, 1);

      // Reset while nested discards the saved entries.
      begin_cyc(); psw_latch = 1; bus_in = 16'h0015;           expect_v("load_r",       16'h0015, 0, 1, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push_r1",      16'h0005, 0, 0, 0, 1);
      begin_cyc(); irq_entry = 1;                              expect_v("push_r2",      16'h0005, 0, 0, 0, 1);
      begin_cyc(); reset = 1; ie_set = 1;                      expect_v("reset_nest",   16'h0000, 0, 1, 0, 1);
      begin_cyc(); irq_return = 1;                             expect_v("pop_after_rst",16'h0000, 0, 1, 1, 1);
      begin_cyc(); reset = 1;                                  expect_v("reset_err",    16'h0000, 0, 1, 0, 1);
      begin_cyc(); psw_latch = 1; bus_in = 16'h0003; ie_set = 1;
                                                                expect_v("latch_over_ie",16'h0003, 0, 1, 0, 1);
      begin_cyc(); irq_return = 1; psw_latch = 1; bus_in = 16'h001F;
                                                                expect_v("ret_over_latch",16'h0003, 0, 1, 1, 1);
      begin_cyc();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      #5;
      if (exp_q.size() > 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
